pipe_ctrl: RTL

//  Parametrised pipeline hazard/flush controller for the 5-stage CPU; generalised successor of the single-source ID stall control.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl_sat_counter.sv | 26 ++
 rtl/pipe_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller.
//   - Stall bus width and stage index constants (PC..WB).
//   - FSM state encoding, also used on the fsm_state debug output.
//   - clamp_stage(): maps an out-of-range stage index onto the last stage.
package pipe_ctrl_pkg;

  localparam int STALL_BUS_W = 6;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } pipe_state_e;

  function automatic int clamp_stage(input int stage, input int stages);
    return (stage >= stages) ? stages - 1 : stage;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, q -> 0
//   clr  : synchronous clear, q -> 0; wins over inc
//   inc  : count by one when set, stopping at MAX
//   q    : current count
module sat_counter #(
  parameter int             W   = 16,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller for the 5-stage CPU.
// Merges per-source stall requests into a per-stage stall bus, issues a
// registered one-cycle flush pulse with redirect PC (which overrides stalls),
// and keeps saturating stall/flush counters plus a sticky stall watchdog.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   stall_req    in   [NREQ]    level stall requests, bit i tied to REQ_STAGE[i]
//   flush_req    in             flush/redirect request
//   flush_pc     in   [PC_W]    redirect target, sampled with flush_req
//   perf_clr     in             synchronous clear of counters and wdog_err
//   stall        out  [STAGES]  per-stage hold, stages 0..s for highest requester s
//   flush        out            one-cycle registered flush pulse
//   new_pc       out  [PC_W]    redirect PC, valid while flush=1, held otherwise
//   stall_cycles out  [CNT_W]   saturating count of cycles with stall[0]=1
//   flush_count  out  [CNT_W]   saturating count of flush pulses
//   wdog_err     out            sticky: stall held WDOG_LIMIT consecutive cycles
//   fsm_state    out            current RUN/STALL/FLUSH state (debug/status)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                STAGES     = STALL_BUS_W,
  parameter int                NREQ       = 3,
  parameter logic [3*NREQ-1:0] REQ_STAGE  = {3'd3, 3'd2, 3'd2},
  parameter int                PC_W       = 32,
  parameter int                CNT_W      = 16,
  parameter int                WDOG_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stall_req,
  input  logic              flush_req,
  input  logic [PC_W-1:0]   flush_pc,
  input  logic              perf_clr,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic              wdog_err,
  output pipe_state_e       fsm_state
);

  // ---------------------------------------------------------------------------
  // Stall mask. Each request contributes a prefix mask (bits 0..stage), so the
  // OR of all active masks equals the mask of the highest requesting stage.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] req_mask [NREQ];
  logic [STAGES-1:0] stall_mask;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    localparam int          STG    = clamp_stage(int'(REQ_STAGE[3*i +: 3]), STAGES);
    localparam logic [63:0] MASK64 = (64'd1 << (STG + 1)) - 64'd1;
    assign req_mask[i] = stall_req[i] ? MASK64[STAGES-1:0] : '0;
  end

  always_comb begin
    stall_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      stall_mask = stall_mask | req_mask[i];
    end
    // A flush cycle squashes the pipe, so holding any stage would be wrong.
    stall = (rst || flush) ? '0 : stall_mask;
  end

  // ---------------------------------------------------------------------------
  // Flush pulse and redirect PC, one cycle after flush_req.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      flush  <= 1'b0;
      new_pc <= '0;
    end else begin
      flush <= flush_req;
      if (flush_req) begin
        new_pc <= flush_pc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status FSM. flush_req outranks stall_req in every state; FLUSH coincides
  // with flush=1.
  // ---------------------------------------------------------------------------
  pipe_state_e state_q;
  pipe_state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush_req)       state_d = ST_FLUSH;
        else if (|stall_req) state_d = ST_STALL;
      end
      ST_STALL: begin
        if (flush_req)       state_d = ST_FLUSH;
        else if (!(|stall_req)) state_d = ST_RUN;
      end
      ST_FLUSH: begin
        if (flush_req)       state_d = ST_FLUSH;
        else if (|stall_req) state_d = ST_STALL;
        else                 state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign fsm_state = state_q;

  // ---------------------------------------------------------------------------
  // Performance counters.
  // ---------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (stall[0]),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (flush),
    .q   (flush_count)
  );

  // ---------------------------------------------------------------------------
  // Stall watchdog. The run length restarts on any non-stalled cycle (flush
  // cycles included) and parks at WDOG_LIMIT; the error is raised on the edge
  // after the limit is reached. WDOG_LIMIT=0 disables the error.
  // ---------------------------------------------------------------------------
  localparam int             RUN_W   = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WDOG_LIMIT);

  logic [RUN_W-1:0] run_len;

  sat_counter #(.W(RUN_W), .MAX(RUN_MAX)) u_run_len (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr || !stall[0]),
    .inc (stall[0]),
    .q   (run_len)
  );

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      wdog_err <= 1'b0;
    end else if ((WDOG_LIMIT != 0) && (run_len == RUN_MAX)) begin
      wdog_err <= 1'b1;
    end
  end

endmodule
